// File: rtl/timer_display_scanner.sv
// timer_display_scanner: multiplexes the centre timer's six BCD digits onto a
// 6-digit common-anode 7-segment display. Digits and flags are snapshotted once
// per frame, each slot begins with anti-ghost dead time, the minute tens digit
// is blanked when zero, both minute digits are blanked in the final minute, and
// the whole display blinks during the final-seconds warning.
module timer_display_scanner #(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEAD_CYCLES  = 500,
  parameter int unsigned BLINK_FRAMES = 83,
  parameter int unsigned CNT_W        = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] min_tens,
  input  logic [3:0] min_ones,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  input  logic [3:0] cs_tens,
  input  logic [3:0] cs_ones,
  input  logic       one_min_left,
  input  logic       ten_sec_left,
  input  logic       time_out,
  output logic [5:0] an,
  output logic [7:0] seg
);

  localparam int unsigned NUM_DIGITS = 6;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned FRAME_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_DEAD   = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  // Slot positions of the digits that carry special display rules
  localparam logic [IDX_W-1:0] IDX_MIN_TENS = IDX_W'(5);
  localparam logic [IDX_W-1:0] IDX_MIN_ONES = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_SEC_ONES = IDX_W'(2);

  // Scan and snapshot state
  logic [CNT_W-1:0]           presc;
  logic [IDX_W-1:0]           idx;
  logic [NUM_DIGITS-1:0][3:0] snap_digits;
  logic                       snap_one_min;
  logic                       snap_ten_sec;
  logic                       snap_time_out;
  logic [FRAME_W-1:0]         frame_cnt;
  logic                       blink_on;

  // Next-state values
  logic [CNT_W-1:0]           presc_nxt;
  logic [IDX_W-1:0]           idx_nxt;
  logic [NUM_DIGITS-1:0][3:0] snap_digits_nxt;
  logic                       snap_one_min_nxt;
  logic                       snap_ten_sec_nxt;
  logic                       snap_time_out_nxt;
  logic [FRAME_W-1:0]         frame_cnt_nxt;
  logic                       blink_on_nxt;

  // Decoded control terms
  logic                       slot_end;
  logic                       frame_end;
  logic                       blink_en;
  logic [NUM_DIGITS-1:0][3:0] live_digits;

  // Combinational display values, registered into an/seg
  logic [5:0] an_c;
  logic [7:0] seg_c;
  logic [3:0] digit_c;
  logic       blank_c;
  logic       dp_c;

  assign live_digits = {min_tens, min_ones, sec_tens, sec_ones, cs_tens, cs_ones};
  assign slot_end    = (presc == CNT_LAST);
  assign frame_end   = slot_end && (idx == IDX_LAST);
  assign blink_en    = snap_ten_sec && !snap_time_out;

  // BCD to active-low a..g; anything outside 0-9 renders as a dash
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] val);
    logic [6:0] s;
    case (val)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // State register: prescaler, digit index, snapshot and blink phase
  always_ff @(posedge clk) begin
    if (rst) begin
      presc         <= '0;
      idx           <= '0;
      snap_digits   <= '0;
      snap_one_min  <= 1'b0;
      snap_ten_sec  <= 1'b0;
      snap_time_out <= 1'b0;
      frame_cnt     <= '0;
      blink_on      <= 1'b1;
    end else begin
      presc         <= presc_nxt;
      idx           <= idx_nxt;
      snap_digits   <= snap_digits_nxt;
      snap_one_min  <= snap_one_min_nxt;
      snap_ten_sec  <= snap_ten_sec_nxt;
      snap_time_out <= snap_time_out_nxt;
      frame_cnt     <= frame_cnt_nxt;
      blink_on      <= blink_on_nxt;
    end
  end

  // Next-state logic: slot timing, frame-end snapshot and blink phase update
  always_comb begin
    presc_nxt         = presc + CNT_W'(1);
    idx_nxt           = idx;
    snap_digits_nxt   = snap_digits;
    snap_one_min_nxt  = snap_one_min;
    snap_ten_sec_nxt  = snap_ten_sec;
    snap_time_out_nxt = snap_time_out;
    frame_cnt_nxt     = frame_cnt;
    blink_on_nxt      = blink_on;

    if (slot_end) begin
      presc_nxt = '0;
      idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end

    if (frame_end) begin
      snap_digits_nxt   = live_digits;
      snap_one_min_nxt  = one_min_left;
      snap_ten_sec_nxt  = ten_sec_left;
      snap_time_out_nxt = time_out;
    end

    // Blink phase uses the flags of the frame just finished; new flags apply next frame
    if (!blink_en) begin
      frame_cnt_nxt = '0;
      blink_on_nxt  = 1'b1;
    end else if (frame_end) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt_nxt = '0;
        blink_on_nxt  = !blink_on;
      end else begin
        frame_cnt_nxt = frame_cnt + FRAME_W'(1);
      end
    end
  end

  // Output logic: select the current digit, apply blanking, dead time and decode
  always_comb begin
    an_c    = '1;
    seg_c   = '1;
    digit_c = '0;
    blank_c = 1'b0;
    dp_c    = 1'b0;

    case (idx)
      IDX_W'(0): digit_c = snap_digits[0];
      IDX_W'(1): digit_c = snap_digits[1];
      IDX_W'(2): digit_c = snap_digits[2];
      IDX_W'(3): digit_c = snap_digits[3];
      IDX_W'(4): digit_c = snap_digits[4];
      IDX_W'(5): digit_c = snap_digits[5];
      default:   blank_c = 1'b1;
    endcase

    if (idx == IDX_MIN_TENS && (snap_digits[5] == 4'd0 || snap_one_min)) begin
      blank_c = 1'b1;
    end
    if (idx == IDX_MIN_ONES && snap_one_min) begin
      blank_c = 1'b1;
    end
    if (blink_en && !blink_on) begin
      blank_c = 1'b1;
    end

    dp_c = (idx == IDX_MIN_ONES) || (idx == IDX_SEC_ONES);

    if (presc >= CNT_DEAD && !blank_c) begin
      an_c  = ~(6'd1 << idx);
      seg_c = {!dp_c, bcd_to_seg(digit_c)};
    end
  end

  // Output register: one cycle behind the scan state, dark in reset
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= '1;
      seg <= '1;
    end else begin
      an  <= an_c;
      seg <= seg_c;
    end
  end

endmodule

// File: tb/tb_timer_display_scanner.sv
// Bench for timer_display_scanner: directed phases with expected display values
// queued against absolute scan positions, then compared as the scan reaches them.
module tb_timer_display_scanner;

  localparam int unsigned SCAN_DIV     = 8;
  localparam int unsigned DEAD_CYCLES  = 2;
  localparam int unsigned BLINK_FRAMES = 2;
  localparam int unsigned CNT_W        = 4;
  localparam int          SLOT         = SCAN_DIV;
  localparam int          FRAME        = 6 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] min_tens = 4'd0;
  logic [3:0] min_ones = 4'd0;
  logic [3:0] sec_tens = 4'd0;
  logic [3:0] sec_ones = 4'd0;
  logic [3:0] cs_tens  = 4'd0;
  logic [3:0] cs_ones  = 4'd0;
  logic       one_min_left = 1'b0;
  logic       ten_sec_left = 1'b0;
  logic       time_out     = 1'b0;
  logic [5:0] an;
  logic [7:0] seg;

  int errors = 0;
  int checks = 0;
  int edges  = 0;

  typedef struct {
    string      tag;
    int         state;
    logic [5:0] an;
    logic [7:0] seg;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  timer_display_scanner #(
    .SCAN_DIV    (SCAN_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .BLINK_FRAMES(BLINK_FRAMES),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .min_tens    (min_tens),
    .min_ones    (min_ones),
    .sec_tens    (sec_tens),
    .sec_ones    (sec_ones),
    .cs_tens     (cs_tens),
    .cs_ones     (cs_ones),
    .one_min_left(one_min_left),
    .ten_sec_left(ten_sec_left),
    .time_out    (time_out),
    .an          (an),
    .seg         (seg)
  );

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    edges++;
  endtask

  task automatic check(input string tag, input logic [5:0] a, input logic [7:0] s);
    checks++;
    assert (an === a && seg === s) else begin
      errors++;
      $error("FAIL %s: got an=%b seg=%h, expected an=%b seg=%h", tag, an, seg, a, s);
    end
  endtask

  // Active-low anode pattern for a lit digit
  function automatic logic [5:0] an_of(input int i);
    return 6'(~(6'd1 << i));
  endfunction

  // Queue an expectation for the output reflecting (frame, idx, prescaler)
  task automatic push(input string tag, input int f, input int i, input int p,
                      input logic [5:0] a, input logic [7:0] s);
    exp_t e;
    e.tag   = tag;
    e.state = f * FRAME + i * SLOT + p;
    e.an    = a;
    e.seg   = s;
    sb.push_back(e);
  endtask

  // Output after edge N reflects scan state N-1 counted from reset release
  task automatic run_to(input int state);
    while (edges < state + 1) tick();
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (edges > e.state + 1) begin
        checks++;
        errors++;
        $display("FAIL %s: scan position %0d already passed (at %0d)", e.tag, e.state, edges - 1);
      end else begin
        run_to(e.state);
        check(e.tag, e.an, e.seg);
      end
    end
  endtask

  // Hold reset for n cycles, checking the dark display each cycle
  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) begin
      tick();
      check("reset_dark", 6'b111111, 8'hFF);
    end
    rst   = 1'b0;
    edges = 0;
  endtask

  initial begin
    // Reset and dead time, all-zero snapshot
    do_reset(3);
    push("dead_p0",      0, 0, 0, 6'b111111, 8'hFF);
    push("dead_p1",      0, 0, 1, 6'b111111, 8'hFF);
    push("slot0_zero",   0, 0, 2, an_of(0), 8'hC0);
    push("slot4_zero",   0, 4, 4, an_of(4), 8'h40);
    push("slot5_blank0", 0, 5, 4, 6'b111111, 8'hFF);
    drain();

    // 10:00:00 held, checked in the second full frame
    min_tens = 4'd1;
    push("f2_idx0",      2, 0, 4, an_of(0), 8'hC0);
    push("f2_idx1",      2, 1, 4, an_of(1), 8'hC0);
    push("f2_idx2_dp",   2, 2, 4, an_of(2), 8'h40);
    push("f2_idx3_dead", 2, 3, 1, 6'b111111, 8'hFF);
    push("f2_idx3",      2, 3, 4, an_of(3), 8'hC0);
    push("f2_idx4_dp",   2, 4, 4, an_of(4), 8'h40);
    push("f2_idx5_one",  2, 5, 4, an_of(5), 8'hF9);
    drain();

    // Mid-frame input change is deferred to the next snapshot
    cs_ones = 4'd3;
    push("f3_idx0_three", 3, 0, 4, an_of(0), 8'hB0);
    drain();
    run_to(3 * FRAME + 2 * SLOT + 4);
    cs_ones = 4'd7;
    push("f3_idx5_hold",  3, 5, 4, an_of(5), 8'hF9);
    push("f4_idx0_seven", 4, 0, 4, an_of(0), 8'hF8);
    drain();

    // Blink: two frames on, two off; time_out makes it steady
    ten_sec_left = 1'b1;
    push("blink_f5_on",  5, 0, 4, an_of(0), 8'hF8);
    push("blink_f6_on",  6, 0, 4, an_of(0), 8'hF8);
    push("blink_f7_off", 7, 0, 4, 6'b111111, 8'hFF);
    push("blink_f8_off", 8, 3, 4, 6'b111111, 8'hFF);
    push("blink_f9_on",  9, 0, 4, an_of(0), 8'hF8);
    drain();
    time_out = 1'b1;
    push("tout_f10", 10, 0, 4, an_of(0), 8'hF8);
    push("tout_f11", 11, 0, 4, an_of(0), 8'hF8);
    push("tout_f12", 12, 0, 4, an_of(0), 8'hF8);
    drain();

    // Final minute: 00:45:12 with both minute digits blanked
    ten_sec_left = 1'b0;
    time_out     = 1'b0;
    one_min_left = 1'b1;
    min_tens = 4'd0; min_ones = 4'd0;
    sec_tens = 4'd4; sec_ones = 4'd5;
    cs_tens  = 4'd1; cs_ones  = 4'd2;
    push("onemin_idx0", 13, 0, 4, an_of(0), 8'hA4);
    push("onemin_idx1", 13, 1, 4, an_of(1), 8'hF9);
    push("onemin_idx2", 13, 2, 4, an_of(2), 8'h12);
    push("onemin_idx3", 13, 3, 4, an_of(3), 8'h99);
    push("onemin_idx4", 13, 4, 4, 6'b111111, 8'hFF);
    push("onemin_idx5", 13, 5, 4, 6'b111111, 8'hFF);
    drain();

    // Non-BCD digit shows a dash
    min_ones     = 4'hC;
    one_min_left = 1'b0;
    push("dash_idx4", 14, 4, 4, an_of(4), 8'h3F);
    push("dash_idx5", 14, 5, 4, 6'b111111, 8'hFF);
    drain();

    // Drive blink into its off phase, then reset at idx3/prescaler5
    ten_sec_left = 1'b1;
    push("pre_rst_on",  15, 0, 4, an_of(0), 8'hA4);
    push("pre_rst_off", 17, 0, 4, 6'b111111, 8'hFF);
    drain();
    run_to(17 * FRAME + 3 * SLOT + 4);
    do_reset(1);
    push("post_rst_dead",  0, 0, 0, 6'b111111, 8'hFF);
    push("post_rst_slot0", 0, 0, 2, an_of(0), 8'hC0);
    push("post_rst_blink", 1, 0, 4, an_of(0), 8'hA4);
    push("post_rst_dash",  1, 4, 4, an_of(4), 8'h3F);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
